pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Drives the flush/freeze side of the ID/EXE pipeline-register interface: decides every cycle whether
//  the IF/ID and ID/EXE registers load, hold (freeze) or clear (flush, i.e. insert a bubble).
//  Consumes the EXE-stage copy of B/WB_EN/MEM_R_EN/Dest and the MEM-stage Dest/WB_EN.
//  Holds a multi-cycle branch-flush FSM and saturating stall/flush event counters for debug.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles flush is held after a taken branch is seen in EXE (1..7)
//  CNT_W         16  width of stall_cnt / flush_cnt
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-low reset
//  src1         in   4      ID-stage Rn index
//  src2         in   4      ID-stage Rm/Rd index
//  two_src      in   1      1: ID instruction reads src2 as well as src1
//  src1_vld     in   1      1: ID instruction reads src1 (0 for MOV/MVN/B)
//  exe_B        in   1      taken branch resolved in EXE (ID/EXE register B output)
//  exe_wb_en    in   1      ID/EXE register WB_EN output
//  exe_mem_r_en in   1      ID/EXE register MEM_R_EN output
//  exe_dest     in   4      ID/EXE register Dest output
//  mem_wb_en    in   1      EXE/MEM register WB_EN output
//  mem_dest     in   4      EXE/MEM register Dest output
//  freeze       out  1      hold PC and IF/ID register
//  flush_if_id  out  1      clear IF/ID register next edge
//  flush_id_ex  out  1      clear ID/EXE register next edge (drives its flush input)
//  stall_cnt    out  CNT_W  cycles with freeze=1, saturating
//  flush_cnt    out  CNT_W  taken branches accepted, saturating
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, fcnt=0, stall_cnt=0, flush_cnt=0; while rst==0 freeze,
//   flush_if_id, flush_id_ex forced 0. Reset mid-FLUSH aborts the flush; nothing is remembered.
//  FSM states IDLE, FLUSH; 3-bit down-counter fcnt.
//   IDLE: exe_B=1 -> flush outputs asserted combinationally this cycle; if FLUSH_CYCLES>1 go FLUSH
//         with fcnt=FLUSH_CYCLES-2, else stay IDLE. flush_cnt+=1 (saturate at all-ones).
//   FLUSH: flush outputs asserted; fcnt==0 -> IDLE, else fcnt-=1. exe_B during FLUSH is ignored
//         (its instruction is itself a flushed bubble) and is not counted.
//  brflush = (state==FLUSH) | (state==IDLE & exe_B).
//  match(d) = (src1_vld & src1==d) | (two_src & src2==d); R15 is not special-cased.
//  hazard per CONFIGURATION below; all comparisons combinational, zero-latency.
//  Priority: brflush beats hazard -> freeze = hazard & ~brflush.
//  flush_if_id = brflush; flush_id_ex = brflush | freeze (bubble behind a stall).
//  stall_cnt += 1 each cycle freeze=1, saturating. Counters update only on rst==1 edges.
//  Simultaneous exe_B and hazard: flush only, no freeze, stall_cnt unchanged.
// CONFIGURATION
//  FORWARDING_EN defined: hazard = exe_wb_en & exe_mem_r_en & match(exe_dest) (load-use only;
//   1-cycle stall, forwarding unit covers the rest); MEM-stage inputs unused.
//  FORWARDING_EN undefined: hazard = (exe_wb_en & match(exe_dest)) | (mem_wb_en & match(mem_dest)).
// STRUCTURE
//  Shared package pipe_pkg: state encoding (ST_IDLE=1'b0, ST_FLUSH=1'b1), REG_IDX_W=4, PC_REG=4'd15.
//  One natural sub-module: hazard_detect (purely combinational match/hazard logic, macro-aware);
//  FSM, flush muxing and counters stay in this module.
// TESTING
//  rst=0 for 2 cycles during FLUSH -> all outputs 0, counters 0, state IDLE after release.
//  FLUSH_CYCLES=3, exe_B=1 one cycle -> flush_if_id/flush_id_ex high 3 cycles, flush_cnt=1.
//  FWD on: exe_mem_r_en=1,exe_wb_en=1,exe_dest=3,src1=3,src1_vld=1 -> freeze=1,flush_id_ex=1 one cycle.
//  FWD off: mem_wb_en=1,mem_dest=5,two_src=1,src2=5 -> freeze=1; FWD on same stimulus -> freeze=0.
//  exe_B=1 together with load-use hazard -> freeze=0, flush both=1, stall_cnt unchanged.
//  CNT_W=4, freeze held 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Build option: FORWARDING_EN selects the load-use-only hazard rule in hazard_detect.
package pipe_pkg;

    localparam int REG_IDX_W = 4;
    localparam logic [REG_IDX_W-1:0] PC_REG = 4'd15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the ID/EXE pipeline registers and the hazard controller.
// Latency: n/a (wires only). Backpressure: freeze is the only stall; no handshake.
// Build option: FORWARDING_EN leaves mem_wb_en/mem_dest unread by the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic                 two_src;
    logic                 src1_vld;
    logic                 exe_B;
    logic                 exe_wb_en;
    logic                 exe_mem_r_en;
    logic [REG_IDX_W-1:0] exe_dest;
    logic                 mem_wb_en;
    logic [REG_IDX_W-1:0] mem_dest;
    logic                 freeze;
    logic                 flush_if_id;
    logic                 flush_id_ex;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    // Pipeline side: supplies stage fields, consumes control.
    modport master (
        output src1, src2, two_src, src1_vld, exe_B, exe_wb_en, exe_mem_r_en,
               exe_dest, mem_wb_en, mem_dest,
        input  freeze, flush_if_id, flush_id_ex, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  src1, src2, two_src, src1_vld, exe_B, exe_wb_en, exe_mem_r_en,
               exe_dest, mem_wb_en, mem_dest,
        output freeze, flush_if_id, flush_id_ex, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Data-hazard detection between the ID sources and the EXE/MEM destinations.
// Latency: purely combinational. Backpressure: none; result feeds the freeze logic.
// Build option: FORWARDING_EN -> only EXE-stage load-use counts; otherwise any pending EXE/MEM write.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src1_i,
    input  logic [REG_IDX_W-1:0] src2_i,
    input  logic                 two_src_i,
    input  logic                 src1_vld_i,
    input  logic                 exe_wb_en_i,
    input  logic                 exe_mem_r_en_i,
    input  logic [REG_IDX_W-1:0] exe_dest_i,
    input  logic                 mem_wb_en_i,
    input  logic [REG_IDX_W-1:0] mem_dest_i,
    output logic                 hazard_o
);

    // R15 is deliberately treated like any other register index.
    function automatic logic src_match(input logic [REG_IDX_W-1:0] dest);
        return (src1_vld_i && (src1_i == dest)) || (two_src_i && (src2_i == dest));
    endfunction

`ifdef FORWARDING_EN
    logic unused_mem_ok;
    assign unused_mem_ok = &{1'b0, mem_wb_en_i, mem_dest_i};

    assign hazard_o = exe_wb_en_i && exe_mem_r_en_i && src_match(exe_dest_i);
`else
    logic unused_rd_ok;
    assign unused_rd_ok = &{1'b0, exe_mem_r_en_i};

    assign hazard_o = (exe_wb_en_i && src_match(exe_dest_i))
                   || (mem_wb_en_i && src_match(mem_dest_i));
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush control for the IF/ID and ID/EXE registers plus debug event counters.
// Latency: controls are combinational (same cycle); counters update on the next edge.
// Backpressure: freeze holds PC and IF/ID; a taken branch overrides any stall. Option: FORWARDING_EN.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [2:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    hz_state_e        state_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             br_taken;
    logic             brflush;
    logic             freeze;

    hazard_detect u_hazard_detect (
        .src1_i         (hz.src1),
        .src2_i         (hz.src2),
        .two_src_i      (hz.two_src),
        .src1_vld_i     (hz.src1_vld),
        .exe_wb_en_i    (hz.exe_wb_en),
        .exe_mem_r_en_i (hz.exe_mem_r_en),
        .exe_dest_i     (hz.exe_dest),
        .mem_wb_en_i    (hz.mem_wb_en),
        .mem_dest_i     (hz.mem_dest),
        .hazard_o       (hazard)
    );

    // A branch seen while already flushing is itself a bubble: not accepted, not counted.
    assign br_taken = (state_q == ST_IDLE) && hz.exe_B;
    assign brflush  = rst && ((state_q == ST_FLUSH) || br_taken);
    assign freeze   = rst && hazard && !brflush;

    assign hz.freeze      = freeze;
    assign hz.flush_if_id = brflush;
    assign hz.flush_id_ex = brflush || freeze;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_taken && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (hz.exe_B && (FLUSH_CYCLES > 1)) begin
                        state_q <= ST_FLUSH;
                        fcnt_q  <= FCNT_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q == 3'd0)
                        state_q <= ST_IDLE;
                    else
                        fcnt_q <= fcnt_q - 3'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3, CNT_W=4).
// Expectations follow FORWARDING_EN when the bench is built with it.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;
    int   exp_stall;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (3),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.src1 = 4'd0; hz.src2 = 4'd0; hz.two_src = 1'b0; hz.src1_vld = 1'b0;
        hz.exe_B = 1'b0; hz.exe_wb_en = 1'b0; hz.exe_mem_r_en = 1'b0; hz.exe_dest = 4'd0;
        hz.mem_wb_en = 1'b0; hz.mem_dest = 4'd0;
    endtask

    task automatic load_use(input logic [3:0] r);
        hz.exe_wb_en = 1'b1; hz.exe_mem_r_en = 1'b1; hz.exe_dest = r;
        hz.src1 = r; hz.src1_vld = 1'b1;
    endtask

    task automatic chk_ctl(input string tag, input logic fz, input logic fi, input logic fe);
        #1;
        chk({tag, ".freeze"}, 32'(hz.freeze), 32'(fz));
        chk({tag, ".flush_if_id"}, 32'(hz.flush_if_id), 32'(fi));
        chk({tag, ".flush_id_ex"}, 32'(hz.flush_id_ex), 32'(fe));
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b0;
        idle_inputs();
        step();
        step();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cnt", 32'(hz.stall_cnt), 0);
        chk("reset.flush_cnt", 32'(hz.flush_cnt), 0);

        rst = 1'b1;
        chk_ctl("idle", 1'b0, 1'b0, 1'b0);

        // Taken branch for one cycle -> three flush cycles.
        hz.exe_B = 1'b1;
        chk_ctl("br.c0", 1'b0, 1'b1, 1'b1);
        step();
        hz.exe_B = 1'b0;
        chk_ctl("br.c1", 1'b0, 1'b1, 1'b1);
        chk("br.flush_cnt", 32'(hz.flush_cnt), 1);
        step();
        chk_ctl("br.c2", 1'b0, 1'b1, 1'b1);
        step();
        chk_ctl("br.c3", 1'b0, 1'b0, 1'b0);

        // Reset held two cycles in the middle of a flush.
        hz.exe_B = 1'b1;
        step();
        hz.exe_B = 1'b0;
        chk("rstmid.flush_cnt", 32'(hz.flush_cnt), 2);
        rst = 1'b0;
        chk_ctl("rstmid.in", 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rstmid.stall_cnt", 32'(hz.stall_cnt), 0);
        chk("rstmid.flush_cnt0", 32'(hz.flush_cnt), 0);
        rst = 1'b1;
        chk_ctl("rstmid.after", 1'b0, 1'b0, 1'b0);

        // Load-use hazard in EXE: one-cycle stall with bubble.
        load_use(4'd3);
        chk_ctl("lu", 1'b1, 1'b0, 1'b1);
        step();
        exp_stall = 1;
        chk("lu.stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));
        idle_inputs();
        chk_ctl("lu.clear", 1'b0, 1'b0, 1'b0);

        // Matching index but src1 not read -> no hazard.
        load_use(4'd3);
        hz.src1_vld = 1'b0;
        chk_ctl("novld", 1'b0, 1'b0, 1'b0);
        idle_inputs();

        // MEM-stage writer matched on src2.
        hz.mem_wb_en = 1'b1; hz.mem_dest = 4'd5; hz.two_src = 1'b1; hz.src2 = 4'd5;
        hz.src1 = 4'd0; hz.src1_vld = 1'b1;
`ifdef FORWARDING_EN
        chk_ctl("mem", 1'b0, 1'b0, 1'b0);
`else
        chk_ctl("mem", 1'b1, 1'b0, 1'b1);
        exp_stall++;
`endif
        step();
        chk("mem.stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));
        idle_inputs();

        // Branch and load-use together: flush wins, no stall counted.
        load_use(4'd7);
        hz.exe_B = 1'b1;
        chk_ctl("both", 1'b0, 1'b1, 1'b1);
        step();
        chk("both.stall_cnt", 32'(hz.stall_cnt), 32'(exp_stall));
        chk("both.flush_cnt", 32'(hz.flush_cnt), 1);
        // exe_B kept high while flushing must be neither accepted nor counted.
        hz.exe_wb_en = 1'b0; hz.exe_mem_r_en = 1'b0;
        chk_ctl("ign.c1", 1'b0, 1'b1, 1'b1);
        step();
        chk_ctl("ign.c2", 1'b0, 1'b1, 1'b1);
        hz.exe_B = 1'b0;
        step();
        chk_ctl("ign.done", 1'b0, 1'b0, 1'b0);
        chk("ign.flush_cnt", 32'(hz.flush_cnt), 1);
        idle_inputs();

        // R15 compares like any register; hold the stall to saturate the counter.
        load_use(4'd15);
        chk_ctl("r15", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step();
        chk("sat.stall_cnt", 32'(hz.stall_cnt), 15);
        chk("sat.freeze", 32'(hz.freeze), 1);
        idle_inputs();
        step();
        chk("sat.hold", 32'(hz.stall_cnt), 15);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
